// File: rtl/dbg_pkg.sv
// Shared debug-link definitions: the frame FSM state encoding, the default
// sync marker, request codes used by the debug decoder, and byte helpers.
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CODE = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } dbg_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Request codes shared with the debug decoder
  localparam logic [7:0] CODE_MEM_DATA = 8'h21;
  localparam logic [7:0] CODE_IMM_DATA = 8'h22;
  localparam logic [7:0] CODE_REG_ADDR = 8'h23;

  // Pick byte idx out of a 32-bit word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // One step of the running XOR checksum.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/debug_frame_tx_if.sv
// Request side (from debug decoder) and byte side (to UART TX) of the
// debug frame transmitter. The framer uses the slave modport; whatever
// drives requests and consumes bytes uses the master modport.
interface debug_frame_tx_if #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output req_valid, req_code, req_data, req_size, tx_ready,
    input  req_ready, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_code, req_data, req_size, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: accepts one (code, data, size) request in IDLE,
// then streams SYNC_BYTE, code, size+1 data bytes LSB first and, when the
// DBG_TX_CHECKSUM_EN macro is defined, an XOR checksum byte over the code
// and data bytes. Bytes are handed over with a valid/ready handshake and
// the next byte follows the transfer cycle with no bubble.
module debug_frame_tx
  import dbg_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         CODE_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  debug_frame_tx_if.slave    bus,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] req_data_s;
  logic [CODE_W-1:0] req_code_s;

  dbg_state_e       state_r;
  logic [7:0]       code_r;
  logic [31:0]      data_r;
  logic [1:0]       size_r;
  logic [1:0]       idx_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic             req_ready_r;
  logic             busy_r;
  logic [CNT_W-1:0] frame_cnt_r;

  logic [7:0]       next_byte_s;
  logic             last_byte_s;
`ifdef DBG_TX_CHECKSUM_EN
  logic [7:0]       csum_r;
  logic [7:0]       csum_next_s;
`endif

  assign req_data_s = bus.req_data;
  assign req_code_s = bus.req_code;

  // Byte following the one currently on the wire, and end-of-data detect
  always_comb begin
    next_byte_s = word_byte(data_r, idx_r + 2'd1);
    last_byte_s = (idx_r == size_r);
  end

`ifdef DBG_TX_CHECKSUM_EN
  // Checksum including the data byte currently being presented
  always_comb begin
    csum_next_s = csum_step(csum_r, tx_data_r);
  end
`endif

  // Frame sequencer: request capture, byte sequencing and frame counting
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      code_r      <= 8'h00;
      data_r      <= 32'h0000_0000;
      size_r      <= 2'd0;
      idx_r       <= 2'd0;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      frame_cnt_r <= '0;
`ifdef DBG_TX_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            code_r      <= 8'(req_code_s);
            data_r      <= 32'(req_data_s);
            size_r      <= bus.req_size;
            idx_r       <= 2'd0;
            tx_data_r   <= SYNC_BYTE;
            tx_valid_r  <= 1'b1;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bus.tx_ready) begin
            tx_data_r <= code_r;
            state_r   <= ST_CODE;
          end
        end
        ST_CODE: begin
          if (bus.tx_ready) begin
            tx_data_r <= word_byte(data_r, 2'd0);
            idx_r     <= 2'd0;
`ifdef DBG_TX_CHECKSUM_EN
            csum_r    <= code_r;
`endif
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.tx_ready) begin
            if (last_byte_s) begin
`ifdef DBG_TX_CHECKSUM_EN
              tx_data_r   <= csum_next_s;
              csum_r      <= csum_next_s;
              state_r     <= ST_CSUM;
`else
              tx_valid_r  <= 1'b0;
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              frame_cnt_r <= frame_cnt_r + CNT_ONE;
              state_r     <= ST_IDLE;
`endif
            end else begin
              idx_r     <= idx_r + 2'd1;
              tx_data_r <= next_byte_s;
`ifdef DBG_TX_CHECKSUM_EN
              csum_r    <= csum_next_s;
`endif
            end
          end
        end
`ifdef DBG_TX_CHECKSUM_EN
        ST_CSUM: begin
          if (bus.tx_ready) begin
            tx_valid_r  <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            frame_cnt_r <= frame_cnt_r + CNT_ONE;
            state_r     <= ST_IDLE;
          end
        end
`endif
        default: begin
          // Unreachable encoding: fall back to a clean idle state
          tx_valid_r  <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data   = tx_data_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.req_ready = req_ready_r;
  assign busy          = busy_r;
  assign frame_cnt     = frame_cnt_r;

endmodule
